// File: rtl/axi_rd_pkg.sv
// Shared state type, constants and sizing helpers for the AXI burst read master.
package axi_rd_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} rd_state_t;

  localparam int BEAT_BYTES  = 16;
  localparam int BOUNDARY_4K = 4096;

  function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
    ceil_div = (num + den - 64'd1) / den;
  endfunction

  function automatic logic [8:0] min_len(input logic [8:0] a, input logic [8:0] b);
    min_len = (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_rd_master_skid.sv
// Two-entry valid/ready skid buffer on the R path with same-cycle bypass when empty.
// Built only when AXI_RD_SKID_EN is defined.
`ifdef AXI_RD_SKID_EN
module axi_rd_skid_buf #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [2];
  logic             rd_ptr_r, wr_ptr_r, full_r;
  logic [1:0]       cnt_r, cnt_n;
  logic             push_s, pop_s, pop_mem_s, store_s;

  assign in_ready  = ~full_r;
  assign empty     = (cnt_r == 2'd0);
  assign push_s    = in_valid & ~full_r;
  assign out_valid = ~empty | push_s;
  assign out_data  = empty ? in_data : mem_r[rd_ptr_r];
  assign pop_s     = out_valid & out_ready;
  assign pop_mem_s = pop_s & ~empty;
  // An incoming beat popped while empty bypasses storage entirely.
  assign store_s   = push_s & ~(pop_s & empty);

  always_comb begin
    cnt_n = cnt_r;
    case ({store_s, pop_mem_s})
      2'b10:   cnt_n = cnt_r + 2'd1;
      2'b01:   cnt_n = cnt_r - 2'd1;
      default: cnt_n = cnt_r;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_r[i] <= '0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
      full_r   <= 1'b0;
    end else begin
      cnt_r  <= cnt_n;
      full_r <= (cnt_n == 2'd2);
      if (store_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_mem_s) rd_ptr_r <= ~rd_ptr_r;
      else           rd_ptr_r <= rd_ptr_r;
    end
  end

endmodule
`endif

// File: rtl/axi_burst_rd_master.sv
// AXI4 read master: splits a byte request into 4 KB-safe INCR bursts and streams R beats out
// as indexed writes. Define AXI_RD_SKID_EN for a registered skid-buffered R path.
module axi_burst_rd_master
  import axi_rd_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH      = 64,
  parameter int AXI_DATA_WIDTH      = 8 * BEAT_BYTES,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int MAX_BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  output logic                           o_done,
  input  logic                           i_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]      i_addr,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_size_bytes,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                     m_axi_arlen,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic                           m_axi_rlast,
  output logic                           o_wren,
  output logic [31:0]                    o_wraddr,
  output logic [AXI_DATA_WIDTH-1:0]      o_wrdata
);

  localparam int AW    = AXI_ADDR_WIDTH;
  localparam int DW    = AXI_DATA_WIDTH;
  localparam int XW    = AXI_XFER_SIZE_WIDTH;
  localparam int BB    = DW / 8;
  localparam int BB_LG = $clog2(BB);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  rd_state_t     state_r;
  logic [AW-1:0] addr_r, addr_n;
  logic [XW-1:0] left_r, left_n;
  logic [OW-1:0] outs_r, outs_n;
  logic [7:0]    ar_len_r, ar_len_n;
  logic          ar_valid_r, done_r;
  logic [31:0]   wr_cnt_r;
  logic [8:0]    left_clip_s, to4k_s, len_s;
  logic          ar_hs_s, r_hs_s, rlast_hs_s, rready_s;
  logic          exit_s, run_n_s, pipe_empty_s, beat_out_s;

  assign ar_hs_s       = ar_valid_r & m_axi_arready;
  assign r_hs_s        = m_axi_rvalid & rready_s;
  assign rlast_hs_s    = r_hs_s & m_axi_rlast;
  assign m_axi_arvalid = ar_valid_r;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arlen   = ar_len_r;
  assign m_axi_rready  = rready_s;
  assign o_done        = done_r;

  // Pointer and beat budget move only on start or on an accepted AR.
  always_comb begin
    addr_n = addr_r;
    left_n = left_r;
    if (state_r == IDLE) begin
      if (i_start) begin
        addr_n = i_addr & ~AW'(BB - 1);
        left_n = XW'(ceil_div(64'(i_size_bytes), 64'(BB)));
      end else begin
        addr_n = addr_r;
      end
    end else if (ar_hs_s) begin
      addr_n = addr_r + ((AW'(ar_len_r) + AW'(1)) << BB_LG);
      left_n = left_r - (XW'(ar_len_r) + XW'(1));
    end else begin
      left_n = left_r;
    end
    outs_n = outs_r;
    case ({ar_hs_s, rlast_hs_s})
      2'b10:   outs_n = outs_r + OW'(1);
      2'b01:   outs_n = outs_r - OW'(1);
      default: outs_n = outs_r;
    endcase
  end

  // Next burst never crosses a 4 KB page; arlen tracks the pointer so it holds under stall.
  always_comb begin
    left_clip_s = (left_n > XW'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : left_n[8:0];
    to4k_s      = 9'((13'(BOUNDARY_4K) - {1'b0, addr_n[11:0]}) >> BB_LG);
    len_s       = min_len(left_clip_s, to4k_s);
    ar_len_n    = 8'(len_s - 9'd1);
    exit_s      = (left_n == {XW{1'b0}}) && (outs_n == {OW{1'b0}}) && pipe_empty_s;
    run_n_s     = (state_r == IDLE) ? i_start : ~exit_s;
  end

  // Request FSM with registered AR channel, done flag and beat index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_r     <= '0;
      left_r     <= '0;
      outs_r     <= '0;
      ar_len_r   <= 8'd0;
      ar_valid_r <= 1'b0;
      done_r     <= 1'b1;
      wr_cnt_r   <= 32'd0;
    end else begin
      addr_r     <= addr_n;
      left_r     <= left_n;
      outs_r     <= outs_n;
      ar_len_r   <= ar_len_n;
      ar_valid_r <= run_n_s && (left_n != {XW{1'b0}}) && (outs_n < OW'(MAX_OUTSTANDING));
      case (state_r)
        IDLE: begin
          if (i_start) begin
            state_r  <= RUN;
            done_r   <= 1'b0;
            wr_cnt_r <= 32'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (exit_s) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
          end else begin
            state_r <= RUN;
          end
          if (beat_out_s) wr_cnt_r <= wr_cnt_r + 32'd1;
          else            wr_cnt_r <= wr_cnt_r;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b1;
        end
      endcase
    end
  end

`ifdef AXI_RD_SKID_EN
  logic          skid_in_ready_s, skid_out_valid_s, skid_empty_s, pop_s;
  logic [DW-1:0] skid_out_data_s;
  logic          wren_r;
  logic [31:0]   wraddr_r;
  logic [DW-1:0] wrdata_r;

  axi_rd_skid_buf #(.WIDTH(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_axi_rvalid & (state_r == RUN)),
    .in_ready  (skid_in_ready_s),
    .in_data   (m_axi_rdata),
    .out_valid (skid_out_valid_s),
    .out_ready (i_ready),
    .out_data  (skid_out_data_s),
    .empty     (skid_empty_s)
  );

  assign rready_s     = skid_in_ready_s & (state_r == RUN);
  assign pop_s        = skid_out_valid_s & i_ready;
  assign beat_out_s   = pop_s;
  assign pipe_empty_s = skid_empty_s & ~r_hs_s;

  // Registered write port fed from the skid head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_r   <= 1'b0;
      wraddr_r <= 32'd0;
      wrdata_r <= '0;
    end else begin
      wren_r <= pop_s;
      if (pop_s) begin
        wraddr_r <= wr_cnt_r;
        wrdata_r <= skid_out_data_s;
      end else if ((state_r == IDLE) && i_start) begin
        wraddr_r <= 32'd0;
      end else begin
        wraddr_r <= wraddr_r;
      end
    end
  end

  assign o_wren   = wren_r;
  assign o_wraddr = wraddr_r;
  assign o_wrdata = wrdata_r;
`else
  assign rready_s     = i_ready & (state_r == RUN);
  assign beat_out_s   = r_hs_s;
  assign pipe_empty_s = 1'b1;
  assign o_wren       = r_hs_s;
  assign o_wraddr     = wr_cnt_r;
  assign o_wrdata     = m_axi_rdata;
`endif

endmodule

// File: tb/tb_axi_burst_rd_master.sv
// Directed bench: behavioural AXI read slave, write-stream log and hand-computed expectations.
`timescale 1ns/1ps
module tb_axi_burst_rd_master;

  logic         clk = 1'b0;
  logic         rst, i_start, o_done, i_ready;
  logic [63:0]  i_addr;
  logic [31:0]  i_size_bytes;
  logic         m_axi_arvalid, m_axi_arready;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic         m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [127:0] m_axi_rdata;
  logic         o_wren;
  logic [31:0]  o_wraddr;
  logic [127:0] o_wrdata;

  axi_burst_rd_master dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_done(o_done), .i_ready(i_ready),
    .i_addr(i_addr), .i_size_bytes(i_size_bytes),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .o_wren(o_wren), .o_wraddr(o_wraddr), .o_wrdata(o_wrdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int len; } burst_t;
  burst_t       rq[$];
  burst_t       ar_log[$];
  logic [31:0]  wa_log[$];
  logic [127:0] wd_log[$];
  logic         ar_en, r_en;
  int           total = 0, bad = 0, cyc = 0, beat_i = 0;
  int           last_wren_cyc = 0, done_cyc = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_data(input logic [63:0] a);
    return {a ^ 64'h5A5A_0000_C3C3_0000, ~a};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI slave: AR queue, in-order bursts, data derived from beat address
  initial begin : slave
    logic ar_hs, r_hs;
    logic [63:0] ar_a;
    logic [7:0] ar_l;
    burst_t b;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid & m_axi_arready;
      ar_a  = m_axi_araddr;
      ar_l  = m_axi_arlen;
      r_hs  = m_axi_rvalid & m_axi_rready;
      @(posedge clk);
      #1;
      if (rst) begin
        rq.delete();
        beat_i = 0;
      end else begin
        if (ar_hs) begin
          b.addr = ar_a;
          b.len  = int'(ar_l);
          rq.push_back(b);
          ar_log.push_back(b);
        end
        if (r_hs) begin
          if (beat_i == rq[0].len) begin
            void'(rq.pop_front());
            beat_i = 0;
          end else begin
            beat_i++;
          end
        end
      end
      m_axi_arready = ar_en;
      m_axi_rvalid  = r_en && (rq.size() > 0);
      if (rq.size() > 0) begin
        m_axi_rdata = mk_data(rq[0].addr + 64'(beat_i * 16));
        m_axi_rlast = (beat_i == rq[0].len);
      end else begin
        m_axi_rdata = '0;
        m_axi_rlast = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (o_wren) begin
      wa_log.push_back(o_wraddr);
      wd_log.push_back(o_wrdata);
      last_wren_cyc = cyc;
    end
  end

  task automatic start_req(input logic [63:0] a, input logic [31:0] sz);
    wa_log.delete(); wd_log.delete(); ar_log.delete();
    i_addr = a; i_size_bytes = sz; i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      tick(1);
      n++;
    end
    done_cyc = cyc;
    check_eq(tag, 128'(o_done), 128'(1));
  endtask

  task automatic check_stream(input string tag, input logic [63:0] base, input int n);
    check_eq({tag, "_cnt"}, 128'(wa_log.size()), 128'(n));
    for (int k = 0; k < n && k < wa_log.size(); k++) begin
      check_eq({tag, "_wa"}, 128'(wa_log[k]), 128'(k));
      check_eq({tag, "_wd"}, wd_log[k], mk_data(base + 64'(k * 16)));
    end
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [63:0] a, input int len);
    if (idx < ar_log.size()) begin
      check_eq({tag, "_addr"}, 128'(ar_log[idx].addr), 128'(a));
      check_eq({tag, "_len"}, 128'(ar_log[idx].len), 128'(len));
    end else begin
      check_eq({tag, "_missing"}, 128'(ar_log.size()), 128'(idx + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_done"}, 128'(o_done), 128'(1));
    check_eq({tag, "_arvalid"}, 128'(m_axi_arvalid), 128'(0));
    check_eq({tag, "_rready"}, 128'(m_axi_rready), 128'(0));
    check_eq({tag, "_wren"}, 128'(o_wren), 128'(0));
    check_eq({tag, "_wraddr"}, 128'(o_wraddr), 128'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; i_start = 1'b0; i_ready = 1'b0; i_addr = '0; i_size_bytes = '0;
    ar_en = 1'b0; r_en = 1'b0;
    tick(2);
    check_reset_outputs("rst");
    rst = 1'b0;
    tick(1);

    // two full 16-beat bursts
    ar_en = 1'b1; r_en = 1'b1; i_ready = 1'b1;
    start_req(64'h1000, 32'd512);
    check_eq("t1_busy", 128'(o_done), 128'(0));
    wait_done("t1_done", 300);
    check_eq("t1_nar", 128'(ar_log.size()), 128'(2));
    check_ar("t1_ar0", 0, 64'h1000, 15);
    check_ar("t1_ar1", 1, 64'h1100, 15);
    check_stream("t1", 64'h1000, 32);
    check_eq("t1_done_lat", 128'(done_cyc - last_wren_cyc), 128'(1));

    // split at the 4 KB page boundary
    start_req(64'h0FC0, 32'd256);
    wait_done("t2_done", 300);
    check_eq("t2_nar", 128'(ar_log.size()), 128'(2));
    check_ar("t2_ar0", 0, 64'h0FC0, 3);
    check_ar("t2_ar1", 1, 64'h1000, 11);
    check_stream("t2", 64'h0FC0, 16);
    check_eq("t2_done_lat", 128'(done_cyc - last_wren_cyc), 128'(1));

    // outstanding limit with R held off
    r_en = 1'b0;
    start_req(64'h0, 32'd4096);
    tick(20);
    check_eq("t3_stall_nar", 128'(ar_log.size()), 128'(4));
    check_eq("t3_stall_arvalid", 128'(m_axi_arvalid), 128'(0));
    r_en = 1'b1;
    wait_done("t3_done", 3000);
    check_eq("t3_nar", 128'(ar_log.size()), 128'(16));
    check_ar("t3_ar15", 15, 64'h0F00, 15);
    check_stream("t3", 64'h0, 256);

    // downstream ready toggling every 3 cycles
    start_req(64'h2000, 32'd256);
    n = 0;
    while (!o_done && n < 600) begin
      if (n % 3 == 0) i_ready = ~i_ready;
      tick(1);
      n++;
    end
    check_eq("t4_done", 128'(o_done), 128'(1));
    check_stream("t4", 64'h2000, 16);
    i_ready = 1'b1;

    // zero-length request
    start_req(64'h5000, 32'd0);
    check_eq("t5_busy", 128'(o_done), 128'(0));
    check_eq("t5_arvalid0", 128'(m_axi_arvalid), 128'(0));
    tick(1);
    check_eq("t5_done", 128'(o_done), 128'(1));
    check_eq("t5_arvalid1", 128'(m_axi_arvalid), 128'(0));
    tick(3);
    check_eq("t5_nar", 128'(ar_log.size()), 128'(0));
    check_eq("t5_nwr", 128'(wa_log.size()), 128'(0));

    // asynchronous reset mid-transfer, then a fresh request
    start_req(64'h3000, 32'd512);
    n = 0;
    while (wa_log.size() < 5 && n < 200) begin
      tick(1);
      n++;
    end
    check_eq("t6_five_beats", 128'(wa_log.size() >= 5), 128'(1));
    rst = 1'b1;
    #2;
    check_reset_outputs("t6_rst");
    tick(2);
    rst = 1'b0;
    tick(1);
    start_req(64'h4000, 32'd64);
    wait_done("t6_done", 200);
    check_eq("t6_nar", 128'(ar_log.size()), 128'(1));
    check_ar("t6_ar0", 0, 64'h4000, 3);
    check_stream("t6", 64'h4000, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
